// File: rtl/change_recorder_pkg.sv
// Shared types and sizing helpers for the change recorder and its record FIFO.
package change_recorder_pkg;

    localparam int TS_W = 32;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [31:0]     value;
    } record_t;

    typedef enum logic [1:0] {
        IDLE,
        TS_BEAT,
        VAL_BEAT
    } ser_state_t;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/record_fifo.sv
// Synchronous record FIFO; read data is registered and lags a push into an empty FIFO by one cycle.
module record_fifo
    import change_recorder_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = count_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  record_t       push_data,
    input  logic          pop,
    output record_t       rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    record_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;

    assign rd_next = rd_ptr + AW'(pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    // NOTE: storage has no reset; only pointers and flags need a defined state.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_next;
            count    <= count + CW'(push) - CW'(pop);
            // Head is valid only if it was already stored before this edge.
            rd_valid <= (count - CW'(pop)) != '0;
            rd_data  <= mem[rd_next];
        end
    end

endmodule

// File: rtl/change_recorder.sv
// Records {timestamp, value} for every change of a monitored vector and streams
// each record as two 32-bit beats over a valid/ready interface.
module change_recorder
    import change_recorder_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CW    = count_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             ENABLE_i,
    input  logic [WIDTH-1:0] INP_i,
    output logic [31:0]      data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             first_o,
    output logic [CW-1:0]    COUNT_o,
    output logic             OVERFLOW_o,
    output logic             ACTIVE_o
);

    logic             en_q;
    logic [TS_W-1:0]  ts_q;
    logic [WIDTH-1:0] prev_q;
    ser_state_t       state;
    logic [31:0]      value_hold;

    logic    rise, change, push_req, push_ok, pop, val_done, busy;
    logic    rd_valid, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    record_t push_rec, rd_rec;

    // NOTE: every signal here gets a value on every path, so no latch is inferred.
    always_comb begin
        rise           = ENABLE_i & ~en_q;
        change         = ACTIVE_o & ENABLE_i & (INP_i != prev_q);
        push_req       = rise | change;
        busy           = (state != IDLE);
        val_done       = (state == VAL_BEAT) & ready_i;
        push_ok        = push_req & ((COUNT_o < CW'(DEPTH)) | val_done) & ~fifo_full;
        pop            = rd_valid & ~fifo_empty & ((state == IDLE) | val_done);
        // ts_q counts cycles since the enable edge as of the previous edge.
        push_rec.ts    = rise ? '0 : ts_q + TS_W'(1);
        push_rec.value = 32'(INP_i);
    end

    // The record being serialized still counts as held until its last beat leaves.
    assign COUNT_o = fifo_count + CW'(busy);

    record_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk_i),
        .rst_n     (reset_n_i),
        .push      (push_ok),
        .push_data (push_rec),
        .pop       (pop),
        .rd_data   (rd_rec),
        .rd_valid  (rd_valid),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            en_q       <= 1'b0;
            ts_q       <= '0;
            prev_q     <= '0;
            ACTIVE_o   <= 1'b0;
            OVERFLOW_o <= 1'b0;
        end else begin
            en_q   <= ENABLE_i;
            prev_q <= INP_i;
            if (rise) begin
                ts_q <= '0;
            end else if (ACTIVE_o) begin
                ts_q <= ts_q + TS_W'(1);
            end
            if (push_req && !push_ok) begin
                OVERFLOW_o <= 1'b1;
                ACTIVE_o   <= 1'b0;
            end else if (rise) begin
                OVERFLOW_o <= 1'b0;
                ACTIVE_o   <= 1'b1;
            end else if (!ENABLE_i) begin
                ACTIVE_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= IDLE;
            data_o     <= '0;
            first_o    <= 1'b0;
            valid_o    <= 1'b0;
            value_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        data_o     <= rd_rec.ts;
                        value_hold <= rd_rec.value;
                        first_o    <= 1'b1;
                        valid_o    <= 1'b1;
                        state      <= TS_BEAT;
                    end
                end
                TS_BEAT: begin
                    if (ready_i) begin
                        data_o  <= value_hold;
                        first_o <= 1'b0;
                        state   <= VAL_BEAT;
                    end
                end
                VAL_BEAT: begin
                    if (ready_i) begin
                        if (pop) begin
                            data_o     <= rd_rec.ts;
                            value_hold <= rd_rec.value;
                            first_o    <= 1'b1;
                            state      <= TS_BEAT;
                        end else begin
                            valid_o <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_recorder.sv
// Scoreboard bench for change_recorder: a cycle-level record model feeds expected beats,
// a negedge monitor checks beats, handshake hold and status outputs.
module tb_change_recorder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk_i = 1'b0;
    logic             reset_n_i;
    logic             ENABLE_i;
    logic [WIDTH-1:0] INP_i;
    logic [31:0]      data_o;
    logic             valid_o;
    logic             ready_i;
    logic             first_o;
    logic [CW-1:0]    COUNT_o;
    logic             OVERFLOW_o;
    logic             ACTIVE_o;

    typedef struct {
        logic [31:0] data;
        logic        first;
    } beat_t;

    beat_t sb_q[$];
    beat_t e_beat;

    int n_tests = 0;
    int n_fail  = 0;
    int n_beats = 0;

    change_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .ENABLE_i   (ENABLE_i),
        .INP_i      (INP_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .first_o    (first_o),
        .COUNT_o    (COUNT_o),
        .OVERFLOW_o (OVERFLOW_o),
        .ACTIVE_o   (ACTIVE_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: records are stamped with cycles elapsed since the enable edge,
    // and the held count is records pushed minus records whose last beat left.
    logic             m_en_prev = 1'b0;
    logic             m_active  = 1'b0;
    logic             m_ovf     = 1'b0;
    logic [WIDTH-1:0] m_prev    = '0;
    int               m_held    = 0;
    longint           cyc       = 0;
    longint           rise_cyc  = 0;
    logic             m_rise;
    logic             m_want;
    logic [31:0]      m_stamp;
    logic             xfer_done = 1'b0;

    always @(posedge clk_i) begin
        if (!reset_n_i) begin
            m_en_prev = 1'b0;
            m_active  = 1'b0;
            m_ovf     = 1'b0;
            m_prev    = '0;
            m_held    = 0;
            sb_q.delete();
        end else begin
            cyc++;
            m_rise = ENABLE_i && !m_en_prev;
            if (m_rise) rise_cyc = cyc;
            m_stamp = 32'(cyc - rise_cyc);
            m_want  = m_rise || (m_active && ENABLE_i && (INP_i != m_prev));
            if (m_want && (m_held < DEPTH || xfer_done)) begin
                sb_q.push_back('{m_stamp, 1'b1});
                sb_q.push_back('{32'(INP_i), 1'b0});
                m_held++;
                if (m_rise) begin
                    m_active = 1'b1;
                    m_ovf    = 1'b0;
                end
            end else if (m_want) begin
                m_ovf    = 1'b1;
                m_active = 1'b0;
            end
            if (!ENABLE_i) m_active = 1'b0;
            if (xfer_done) m_held--;
            m_en_prev = ENABLE_i;
            m_prev    = INP_i;
        end
    end

    logic        hold_pend  = 1'b0;
    logic [31:0] hold_data  = '0;
    logic        hold_first = 1'b0;

    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            hold_pend = 1'b0;
            xfer_done = 1'b0;
        end else begin
            check("count", 32'(COUNT_o), 32'(m_held));
            check("overflow", 32'(OVERFLOW_o), 32'(m_ovf));
            check("active", 32'(ACTIVE_o), 32'(m_active));
            if (hold_pend) begin
                check("hold_valid", 32'(valid_o), 32'(1));
                check("hold_data", data_o, hold_data);
                check("hold_first", 32'(first_o), 32'(hold_first));
            end
            xfer_done = valid_o && ready_i && !first_o;
            if (valid_o && ready_i) begin
                n_beats++;
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got data 0x%08h first %0b, expected no beat (t=%0t)",
                             data_o, first_o, $time);
                end else begin
                    e_beat = sb_q.pop_front();
                    check("beat_data", data_o, e_beat.data);
                    check("beat_first", 32'(first_o), 32'(e_beat.first));
                end
            end
            hold_pend  = valid_o && !ready_i;
            hold_data  = data_o;
            hold_first = first_o;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!valid_o && k < 50) begin
            tick();
            k++;
        end
        check(name, 32'(valid_o), 32'(1));
    endtask

    task automatic check_status(input string name, input int cnt, input logic ovf, input logic act);
        check({name, "_count"}, 32'(COUNT_o), 32'(cnt));
        check({name, "_overflow"}, 32'(OVERFLOW_o), 32'(ovf));
        check({name, "_active"}, 32'(ACTIVE_o), 32'(act));
    endtask

    int beats0;
    int pct;
    int k;

    initial begin
        reset_n_i = 1'b0;
        ENABLE_i  = 1'b0;
        INP_i     = 8'h05;
        ready_i   = 1'b1;
        tick(2);
        reset_n_i = 1'b1;
        check("reset_valid", 32'(valid_o), 32'(0));
        check("reset_first", 32'(first_o), 32'(0));
        check("reset_data", data_o, 32'h0);
        check_status("reset", 0, 1'b0, 1'b0);

        // Test 1: enable edge at cycle 10, valid at cycle 12.
        tick(9);
        ENABLE_i = 1'b1;
        tick();
        check("t1_valid_e0", 32'(valid_o), 32'(0));
        tick();
        check("t1_valid_e1", 32'(valid_o), 32'(0));
        tick();
        check("t1_valid_e2", 32'(valid_o), 32'(1));
        check("t1_ts_beat", data_o, 32'h0);
        check("t1_first", 32'(first_o), 32'(1));

        // Test 2: change sampled 7 edges after the enable edge.
        tick(4);
        INP_i = 8'h0A;
        tick();
        tick(50);
        check("t2_beats", 32'(n_beats), 32'(4));
        check("t2_queue", 32'(sb_q.size()), 32'(0));

        // Test 3: overflow with the sink stalled.
        ready_i  = 1'b0;
        ENABLE_i = 1'b0;
        tick(2);
        ENABLE_i = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            INP_i = INP_i ^ 8'h01;
            tick();
        end
        check_status("t3_full", DEPTH, 1'b0, 1'b1);
        INP_i = INP_i ^ 8'h01;
        tick();
        check_status("t3_drop", DEPTH, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            INP_i = INP_i ^ 8'h01;
            tick();
        end
        check_status("t3_ignored", DEPTH, 1'b1, 1'b0);
        beats0  = n_beats;
        ready_i = 1'b1;
        tick(20);
        check("t3_beats", 32'(n_beats - beats0), 32'(8));
        check("t3_count", 32'(COUNT_o), 32'(0));

        // Test 4: back-pressure on the value beat; new enable edge clears overflow.
        ready_i  = 1'b0;
        ENABLE_i = 1'b0;
        INP_i    = 8'h3C;
        tick();
        ENABLE_i = 1'b1;
        tick();
        check_status("t4_restart", 1, 1'b0, 1'b1);
        wait_valid("t4_wait_valid");
        check("t4_ts_restart", data_o, 32'h0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("t4_hold_valid", 32'(valid_o), 32'(1));
            check("t4_hold_first", 32'(first_o), 32'(0));
            check("t4_hold_data", data_o, 32'h3C);
            tick();
        end
        ready_i = 1'b1;
        tick();
        check("t4_done_valid", 32'(valid_o), 32'(0));

        // Test 5: change on the disabling edge is not recorded.
        ENABLE_i = 1'b0;
        INP_i    = 8'h99;
        tick();
        check("t5_inactive", 32'(ACTIVE_o), 32'(0));
        beats0 = n_beats;
        INP_i  = 8'h55;
        tick(5);
        check("t5_no_beats", 32'(n_beats - beats0), 32'(0));
        check("t5_count", 32'(COUNT_o), 32'(0));
        ENABLE_i = 1'b1;
        tick();
        check("t5_active", 32'(ACTIVE_o), 32'(1));
        tick(6);
        check("t5_restart_beats", 32'(n_beats - beats0), 32'(2));

        // Test 6: asynchronous reset during the value beat.
        ready_i  = 1'b0;
        ENABLE_i = 1'b0;
        tick();
        INP_i    = 8'h42;
        ENABLE_i = 1'b1;
        tick();
        wait_valid("t6_wait_valid");
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        #2;
        reset_n_i = 1'b0;
        #1;
        check("t6_valid", 32'(valid_o), 32'(0));
        check_status("t6_reset", 0, 1'b0, 1'b0);
        ENABLE_i = 1'b0;
        tick(2);
        reset_n_i = 1'b1;
        beats0    = n_beats;
        ready_i   = 1'b1;
        tick(10);
        check("t6_no_stale", 32'(n_beats - beats0), 32'(0));
        check("t6_idle_valid", 32'(valid_o), 32'(0));

        // Randomized traffic with varying sink throughput.
        for (int seg = 0; seg < 6; seg++) begin
            pct = (seg % 3 == 0) ? 15 : ((seg % 3 == 1) ? 60 : 95);
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 29) == 0) ENABLE_i = ~ENABLE_i;
                if ($urandom_range(0, 3) == 0) INP_i = WIDTH'($urandom);
                ready_i = ($urandom_range(0, 99) < pct);
                tick();
            end
        end

        ENABLE_i = 1'b0;
        ready_i  = 1'b1;
        k = 0;
        while ((sb_q.size() != 0 || valid_o) && k < 100) begin
            tick();
            k++;
        end
        tick(2);
        check("drain_queue", 32'(sb_q.size()), 32'(0));
        check("drain_valid", 32'(valid_o), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
